// File: rtl/dmem_pkg.sv
// dmem_pkg: shared types and helpers for the wait-stated big-endian data memory.
// Byte lane i always corresponds to address offset i (lane 0 = MSB of a word).
package dmem_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10
  } dmem_size_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } dmem_state_t;

  // Lane enables for an access; all-zero means misaligned or illegal size.
  function automatic logic [3:0] byte_en(input logic [1:0] size, input logic [1:0] off);
    logic [3:0] be;
    be = 4'b0000;
    case (size)
      SZ_BYTE: be = 4'b0001 << off;
      SZ_HALF: be = off[0] ? 4'b0000 : (4'b0011 << off);
      SZ_WORD: be = (off == 2'b00) ? 4'b1111 : 4'b0000;
      default: be = 4'b0000;
    endcase
    return be;
  endfunction

  // Replicate right-aligned store data so every enabled lane sees its byte.
  function automatic logic [31:0] lane_data(input logic [1:0] size, input logic [31:0] wdata);
    logic [31:0] r;
    case (size)
      SZ_BYTE: r = {4{wdata[7:0]}};
      SZ_HALF: r = {2{wdata[15:0]}};
      default: r = wdata;
    endcase
    return r;
  endfunction

  // Pick the addressed byte/halfword out of a big-endian word and extend it.
  function automatic logic [31:0] extend(input logic [31:0] word, input logic [1:0] size,
                                         input logic [1:0] off, input logic uns);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    case (off)
      2'd0:    b = word[31:24];
      2'd1:    b = word[23:16];
      2'd2:    b = word[15:8];
      default: b = word[7:0];
    endcase
    h = off[1] ? word[15:0] : word[31:16];
    case (size)
      SZ_BYTE: r = uns ? {24'h0, b} : {{24{b[7]}}, b};
      SZ_HALF: r = uns ? {16'h0, h} : {{16{h[15]}}, h};
      SZ_WORD: r = word;
      default: r = 32'h0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/dmem_ws_bank.sv
// dmem_ws_bank: four byte-lane RAMs with per-lane write enable and a
// registered read port; write and read happen together when en is high.
module dmem_ws_bank #(
  parameter int DEPTH = 1024,
  parameter int IW    = 8
) (
  input  logic          clk,
  input  logic          en,
  input  logic [3:0]    we,
  input  logic [IW-1:0] idx,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    logic [7:0] mem [DEPTH/4];
    logic [7:0] rd_q;

    // Lane gi: optional byte write plus registered read of the old contents.
    always_ff @(posedge clk) begin
      if (en) begin
        if (we[gi]) begin
          mem[idx] <= wdata[31-8*gi -: 8];
        end
        rd_q <= mem[idx];
      end
    end

    assign rdata[31-8*gi -: 8] = rd_q;
  end

endmodule

// File: rtl/dmem_ws.sv
// dmem_ws: byte-addressed big-endian data memory with valid/ready request,
// WAIT_CYCLES wait states and sign/zero-extended sub-word loads.
// Optional feature macro: DMEM_BOUNDS_CHECK_EN (error on addresses >= DEPTH;
// when undefined, addresses wrap modulo DEPTH).
module dmem_ws
  import dmem_pkg::*;
#(
  parameter int DEPTH       = 1024,
  parameter int ADDR_W      = 32,
  parameter int WAIT_CYCLES = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err
);

  localparam int         AW       = $clog2(DEPTH);
  localparam int         IW       = (AW > 2) ? AW - 2 : 1;
  localparam bit         NO_WAIT  = (WAIT_CYCLES == 0);
  localparam logic [3:0] CNT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  dmem_state_t       state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              we_q, we_d;
  logic [1:0]        size_q, size_d;
  logic              uns_q, uns_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              err_q, err_d;
  logic              req_ready_q, req_ready_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [31:0]       rsp_rdata_q, rsp_rdata_d;
  logic              rsp_err_q, rsp_err_d;

  logic              accept;
  logic              acc_go;
  logic              acc_we;
  logic [1:0]        acc_size;
  logic [ADDR_W-1:0] acc_addr;
  logic [31:0]       acc_wdata;
  logic [3:0]        acc_be;
  logic              acc_oob;
  logic              acc_err;
  logic [31:0]       bank_rdata;

  assign accept = req_ready_q & req_valid;

  // Without wait states the memory is accessed on the acceptance edge itself,
  // so the request is taken straight from the ports instead of the latches.
  assign acc_go    = NO_WAIT ? accept    : (state_q == WAIT) && (cnt_q == 4'd0);
  assign acc_we    = NO_WAIT ? req_we    : we_q;
  assign acc_size  = NO_WAIT ? req_size  : size_q;
  assign acc_addr  = NO_WAIT ? req_addr  : addr_q;
  assign acc_wdata = NO_WAIT ? req_wdata : wdata_q;
  assign acc_be    = byte_en(acc_size, acc_addr[1:0]);

`ifdef DMEM_BOUNDS_CHECK_EN
  assign acc_oob = (acc_addr >> AW) != '0;
`else
  // Upper address bits are ignored: the memory simply wraps.
  logic unused_addr_hi;
  assign unused_addr_hi = |(acc_addr >> AW);
  assign acc_oob = 1'b0;
`endif

  assign acc_err = (acc_be == 4'b0000) | acc_oob;

  dmem_ws_bank #(
    .DEPTH (DEPTH),
    .IW    (IW)
  ) u_bank (
    .clk   (clk),
    .en    (acc_go),
    .we    ((acc_we && !acc_err) ? acc_be : 4'b0000),
    .idx   (IW'(acc_addr[AW-1:0] >> 2)),
    .wdata (lane_data(acc_size, acc_wdata)),
    .rdata (bank_rdata)
  );

  // Next-state logic for the IDLE/WAIT/RESP handshake and registered outputs.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    we_d        = we_q;
    size_d      = size_q;
    uns_d       = uns_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    err_d       = err_q;
    req_ready_d = req_ready_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    case (state_q)
      IDLE: begin
        req_ready_d = 1'b1;
        if (accept) begin
          we_d        = req_we;
          size_d      = req_size;
          uns_d       = req_unsigned;
          addr_d      = req_addr;
          wdata_d     = req_wdata;
          cnt_d       = CNT_INIT;
          req_ready_d = 1'b0;
          if (NO_WAIT) begin
            state_d = RESP;
            err_d   = acc_err;
          end else begin
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d = RESP;
          err_d   = acc_err;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP: begin
        state_d     = IDLE;
        req_ready_d = 1'b1;
        rsp_valid_d = 1'b1;
        rsp_err_d   = err_q;
        rsp_rdata_d = (we_q || err_q) ? 32'h0 : extend(bank_rdata, size_q, addr_q[1:0], uns_q);
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers; memory contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= 4'd0;
      we_q        <= 1'b0;
      size_q      <= 2'b00;
      uns_q       <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= 32'h0;
      err_q       <= 1'b0;
      req_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 32'h0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      we_q        <= we_d;
      size_q      <= size_d;
      uns_q       <= uns_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      err_q       <= err_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

endmodule
